// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between a CPU port and an
// IO/loader port. Every access holds its strobe for WAIT_CYC cycles and is closed by a one-cycle ack.
module sram_access_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 3
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,

    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_ack,

    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,

    output logic              busy,
    output logic              grant_io,
    output logic [1:0]        state_dbg
);

    // Handshake: a requester raises req with stable we/addr/wdata and keeps
    // them stable until it sees its one-cycle ack. req still high in the ack
    // cycle is a fresh request, arbitrated in the following IDLE cycle.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC);

    state_t      state;
    logic        last_grant;
    logic        lat_we;
    logic [3:0]  wait_cnt;

    logic              pick_io;
    logic              any_req;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // On a tie the port that did not own the previous access wins.
    always_comb begin
        any_req = cpu_req | io_req;
        pick_io = 1'b0;
        if (cpu_req && io_req) begin
            pick_io = ~last_grant;
        end else begin
            pick_io = io_req;
        end
        sel_we    = pick_io ? io_we    : cpu_we;
        sel_addr  = pick_io ? io_addr  : cpu_addr;
        sel_wdata = pick_io ? io_wdata : cpu_wdata;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            lat_we      <= 1'b0;
            wait_cnt    <= 4'd0;
            grant_io    <= 1'b0;
            cpu_ack     <= 1'b0;
            io_ack      <= 1'b0;
            cpu_rdata   <= '0;
            io_rdata    <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            cpu_ack <= 1'b0;
            io_ack  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state      <= S_ACCESS;
                        grant_io   <= pick_io;
                        last_grant <= pick_io;
                        lat_we     <= sel_we;
                        wait_cnt   <= WAIT_LOAD;
                        sram_ce_n  <= 1'b0;
                        sram_addr  <= sel_addr;
                        if (sel_we) begin
                            sram_we_n   <= 1'b0;
                            sram_dq_oe  <= 1'b1;
                            sram_dq_out <= sel_wdata;
                        end else begin
                            sram_oe_n <= 1'b0;
                        end
                    end
                end

                S_ACCESS: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state     <= S_DONE;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        // Read data is sampled while OE is still low.
                        if (!lat_we) begin
                            if (grant_io) begin
                                io_rdata <= sram_dq_in;
                            end else begin
                                cpu_rdata <= sram_dq_in;
                            end
                        end
                        if (grant_io) begin
                            io_ack <= 1'b1;
                        end else begin
                            cpu_ack <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // Write data and address were held through this cycle after WE rose.
                    state      <= S_IDLE;
                    sram_dq_oe <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule
